jk_cmd_sequencer: RTL and testbench



---
 rtl/jk_cmd_sequencer_if.sv | 15 +
 rtl/jk_cmd_sequencer.sv | 136 +++++++++++++
 tb/tb_jk_cmd_sequencer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/jk_cmd_sequencer_if.sv
// Command channel for jk_cmd_sequencer: valid/ready handshake carrying
// {op, lane mask, repeat count}.
interface jk_cmd_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             valid;
    logic             ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] mask;
    logic [CNT_W-1:0] count;

    modport master (output valid, op, mask, count, input ready);
    modport slave  (input valid, op, mask, count, output ready);
endinterface

// File: rtl/jk_cmd_sequencer.sv
// Command-driven j/k stimulus stage for a bank of WIDTH JK flip-flops.
// Commands are queued in a small FIFO and each one is replayed onto j/k
// for count+1 cycles; q_exp tracks what the driven flops should hold.
module jk_cmd_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    jk_cmd_sequencer_if.slave cmd,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q_exp,
    output logic             busy,
    output logic             done
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = 2 + WIDTH + CNT_W;
    localparam logic [PTR_W:0] OCC_FULL = (PTR_W+1)'(DEPTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] rem, rem_n;

    logic [ENT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   occ, occ_n;
    logic             full, empty, push, pop, last;

    logic [1:0]       head_op;
    logic [WIDTH-1:0] head_mask;
    logic [CNT_W-1:0] head_count;

    logic [WIDTH-1:0] j_n, k_n, q_n;
    logic             done_n, busy_n;

    assign full      = (occ == OCC_FULL);
    assign empty     = (occ == '0);
    assign cmd.ready = ~full;
    assign push      = cmd.valid & ~full;
    assign last      = (state == RUN) && (rem == '0);
    assign pop       = ((state == IDLE) || last) && !empty;
    assign {head_op, head_mask, head_count} = mem[rd_ptr];

    // FIFO storage, written on every accepted command
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {cmd.op, cmd.mask, cmd.count};
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            occ <= occ_n;
        end
    end

    // Executor state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            rem   <= '0;
        end else begin
            state <= state_n;
            rem   <= rem_n;
        end
    end

    // Executor next state: pop a command, count down, or fall back to IDLE
    always_comb begin
        state_n = state;
        rem_n   = rem;
        if (pop) begin
            state_n = RUN;
            rem_n   = head_count;
        end else if (state == RUN) begin
            if (rem != '0)
                rem_n = rem - 1'b1;
            else
                state_n = IDLE;
        end
        case ({push, pop})
            2'b10:   occ_n = occ + 1'b1;
            2'b01:   occ_n = occ - 1'b1;
            default: occ_n = occ;
        endcase
    end

    // Output next values; j/k hold between pops, q_exp follows JK rules
    always_comb begin
        j_n = j;
        k_n = k;
        if (pop) begin
            j_n = head_mask & {WIDTH{head_op[1]}};
            k_n = head_mask & {WIDTH{head_op[0]}};
        end else if (last) begin
            j_n = '0;
            k_n = '0;
        end
        for (int unsigned i = 0; i < WIDTH; i++) begin
            case ({j[i], k[i]})
                2'b00:   q_n[i] = q_exp[i];
                2'b01:   q_n[i] = 1'b0;
                2'b10:   q_n[i] = 1'b1;
                default: q_n[i] = ~q_exp[i];
            endcase
        end
        done_n = last;
        busy_n = (state_n == RUN) || (occ_n != '0);
    end

    // Output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            j     <= '0;
            k     <= '0;
            q_exp <= '0;
            done  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            j     <= j_n;
            k     <= k_n;
            q_exp <= q_n;
            done  <= done_n;
            busy  <= busy_n;
        end
    end
endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Randomized self-checking bench for jk_cmd_sequencer against a queue-based
// reference model.
module tb_jk_cmd_sequencer;
    localparam int WIDTH = 4;
    localparam int CNT_W = 8;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [WIDTH-1:0] j, k, q_exp;
    logic busy, done;

    jk_cmd_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) cif ();

    jk_cmd_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .cmd   (cif),
        .j     (j),
        .k     (k),
        .q_exp (q_exp),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]       op;
        logic [WIDTH-1:0] mask;
        int               count;
    } cmd_t;

    cmd_t             mq[$];
    bit               m_run;
    int               m_rem;
    logic [WIDTH-1:0] m_j, m_k, m_q;
    bit               m_done, m_busy;
    bit               last_acc;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_run = 0; m_rem = 0;
        m_j = '0; m_k = '0; m_q = '0;
        m_done = 0; m_busy = 0;
    endtask

    task automatic check_outputs();
        check("j", 32'(j), 32'(m_j));
        check("k", 32'(k), 32'(m_k));
        check("q_exp", 32'(q_exp), 32'(m_q));
        check("done", 32'(done), 32'(m_done));
        check("busy", 32'(busy), 32'(m_busy));
        check("ready", 32'(cif.ready), 32'(mq.size() < DEPTH));
    endtask

    // One clock edge: advance the reference model on the inputs present at
    // the edge, then compare all outputs 1 time unit later.
    task automatic tick();
        bit   push, pop;
        cmd_t c;
        @(posedge clk);
        last_acc = cif.valid && cif.ready;
        push   = cif.valid && (mq.size() < DEPTH);
        pop    = (!m_run || m_rem == 0) && (mq.size() > 0);
        m_done = m_run && (m_rem == 0);
        m_q    = (m_j & ~m_q) | (~m_k & m_q);
        if (pop) begin
            c     = mq.pop_front();
            m_run = 1;
            m_rem = c.count;
            m_j   = c.mask & {WIDTH{c.op[1]}};
            m_k   = c.mask & {WIDTH{c.op[0]}};
        end else if (m_run && m_rem > 0) begin
            m_rem--;
        end else if (m_run) begin
            m_run = 0;
            m_j = '0;
            m_k = '0;
        end
        if (push) begin
            c.op = cif.op; c.mask = cif.mask; c.count = int'(cif.count);
            mq.push_back(c);
        end
        m_busy = m_run || (mq.size() > 0);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        cif.valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input logic [1:0] op, input logic [WIDTH-1:0] mask, input int cnt);
        int waited;
        cif.valid = 1'b1; cif.op = op; cif.mask = mask; cif.count = CNT_W'(cnt);
        waited = 0;
        do begin
            tick();
            waited++;
        end while (!last_acc && waited < 2000);
        check("send_accepted", 32'(last_acc), 32'd1);
        cif.valid = 1'b0;
    endtask

    // Asynchronous reset placed between edges; outputs must clear at once.
    task automatic apply_reset();
        #2 reset = 1'b1;
        #1;
        check("rst_j", 32'(j), 32'd0);
        check("rst_k", 32'(k), 32'd0);
        check("rst_q", 32'(q_exp), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ready", 32'(cif.ready), 32'd1);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        int acc, waited;
        cif.valid = 1'b0; cif.op = '0; cif.mask = '0; cif.count = '0;
        model_reset();
        apply_reset();
        idle(2);

        // Set all lanes once
        send(2'b10, 4'hF, 0);
        idle(4);
        // Toggle all lanes for three cycles
        apply_reset();
        send(2'b11, 4'hF, 2);
        idle(6);
        // Back-to-back set then clear
        apply_reset();
        send(2'b10, 4'h3, 0);
        send(2'b01, 4'h1, 1);
        idle(6);
        // Hold op with q_exp = 5
        apply_reset();
        send(2'b10, 4'h5, 0);
        idle(3);
        send(2'b00, 4'hF, 3);
        idle(7);

        // Continuous valid with long commands: exactly 5 accepted, then stall
        acc = 0;
        cif.valid = 1'b1; cif.count = 8'd255;
        cif.op = 2'($urandom); cif.mask = WIDTH'($urandom);
        for (int i = 0; i < 200; i++) begin
            tick();
            if (last_acc) begin
                acc++;
                cif.op = 2'($urandom); cif.mask = WIDTH'($urandom);
            end
        end
        check("fill_accepts", 32'(acc), 32'd5);
        waited = 0;
        do begin
            tick();
            waited++;
        end while (!last_acc && waited < 400);
        check("refill_accept", 32'(last_acc), 32'd1);
        cif.valid = 1'b0;
        waited = 0;
        while (busy && waited < 2000) begin
            tick();
            waited++;
        end
        check("drain_idle", 32'(busy), 32'd0);

        // Reset in the middle of a command
        send(2'b11, 4'hF, 10);
        idle(3);
        apply_reset();
        idle(3);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            cif.valid = 1'($urandom);
            cif.op    = 2'($urandom);
            cif.mask  = WIDTH'($urandom);
            cif.count = CNT_W'($urandom_range(0, 3));
            tick();
        end
        idle(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
